// File: rtl/core_mem_arb.sv
// Merges the core's instruction and data request ports onto one memory channel
// through a registered output stage, and routes id-tagged responses back as acks.
module core_mem_arb #(
    parameter int ARB_RR   = 1,
    parameter int NC_ORDER = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ack,
    output logic [31:0] i_ack_rdata,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata,
    output logic        m_req_val,
    input  logic        m_req_ready,
    output logic [31:0] m_req_addr,
    output logic [2:0]  m_req_cop,
    output logic [31:0] m_req_wdata,
    output logic [2:0]  m_req_size,
    output logic        m_req_id,
    input  logic        m_resp_val,
    input  logic        m_resp_id,
    input  logic [31:0] m_resp_rdata,
    output logic        err_unexp
);

    typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_t;

    localparam logic RR_EN = (ARB_RR != 0);
    localparam logic NC_EN = (NC_ORDER != 0);

    logic pend_i;
    logic pend_d;
    logic pend_nc;
    src_t last_grant;

    logic i_elig;
    logic d_elig;
    logic reg_free;
    logic grant_d;
    logic load;
    logic i_resp;
    logic d_resp;

    // An instruction fetch may not overtake a pending non-cacheable data access.
    always_comb begin
        i_elig   = i_req_val & ~pend_i & ~(NC_EN & pend_d & pend_nc);
        d_elig   = d_req_val & ~pend_d;
        reg_free = ~m_req_val | m_req_ready;
        grant_d  = d_elig & (~i_elig | ~RR_EN | (last_grant == SRC_I));
        load     = reg_free & (i_elig | d_elig);
        i_resp   = m_resp_val & ~m_resp_id;
        d_resp   = m_resp_val & m_resp_id;
    end

    assign i_req_ack   = i_resp & pend_i;
    assign d_req_ack   = d_resp & pend_d;
    assign i_ack_rdata = m_resp_rdata;
    assign d_ack_rdata = m_resp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_val   <= 1'b0;
            m_req_addr  <= '0;
            m_req_cop   <= '0;
            m_req_wdata <= '0;
            m_req_size  <= '0;
            m_req_id    <= 1'b0;
            pend_i      <= 1'b0;
            pend_d      <= 1'b0;
            pend_nc     <= 1'b0;
            last_grant  <= SRC_D;
            err_unexp   <= 1'b0;
        end else begin
            if (reg_free) begin
                m_req_val <= load;
                if (load) begin
                    last_grant <= grant_d ? SRC_D : SRC_I;
                    m_req_id   <= grant_d;
                    if (grant_d) begin
                        m_req_addr  <= d_req_addr;
                        m_req_cop   <= d_req_cop;
                        m_req_wdata <= d_req_wdata;
                        m_req_size  <= d_req_size;
                    end else begin
                        m_req_addr  <= i_req_addr;
                        m_req_cop   <= 3'b000;
                        m_req_wdata <= '0;
                        m_req_size  <= 3'b100;
                    end
                end
            end

            // A load for a source is impossible while its own response is due.
            if (i_resp & pend_i) begin
                pend_i <= 1'b0;
            end else if (load & ~grant_d) begin
                pend_i <= 1'b1;
            end

            if (d_resp & pend_d) begin
                pend_d  <= 1'b0;
                pend_nc <= 1'b0;
            end else if (load & grant_d) begin
                pend_d  <= 1'b1;
                pend_nc <= d_req_cop[1];
            end

            if ((i_resp & ~pend_i) | (d_resp & ~pend_d)) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_arb.sv
// Directed testbench for core_mem_arb: a round-robin instance with NC ordering
// and a fixed-data-priority instance sharing the same stimulus.
module tb_core_mem_arb;

    logic        clk;
    logic        rst_n;
    logic        i_req_val;
    logic [31:0] i_req_addr;
    logic        d_req_val;
    logic [31:0] d_req_addr;
    logic [2:0]  d_req_cop;
    logic [31:0] d_req_wdata;
    logic [2:0]  d_req_size;
    logic        m_req_ready;
    logic        m_resp_val;
    logic        m_resp_id;
    logic [31:0] m_resp_rdata;

    logic        i_req_ack;
    logic [31:0] i_ack_rdata;
    logic        d_req_ack;
    logic [31:0] d_ack_rdata;
    logic        m_req_val;
    logic [31:0] m_req_addr;
    logic [2:0]  m_req_cop;
    logic [31:0] m_req_wdata;
    logic [2:0]  m_req_size;
    logic        m_req_id;
    logic        err_unexp;

    logic        fp_i_req_ack;
    logic [31:0] fp_i_ack_rdata;
    logic        fp_d_req_ack;
    logic [31:0] fp_d_ack_rdata;
    logic        fp_m_req_val;
    logic [31:0] fp_m_req_addr;
    logic [2:0]  fp_m_req_cop;
    logic [31:0] fp_m_req_wdata;
    logic [2:0]  fp_m_req_size;
    logic        fp_m_req_id;
    logic        fp_err_unexp;

    int n_cmp;
    int n_fail;

    core_mem_arb #(.ARB_RR(1), .NC_ORDER(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr),
        .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
        .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
        .m_req_val(m_req_val), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_cop(m_req_cop), .m_req_wdata(m_req_wdata), .m_req_size(m_req_size),
        .m_req_id(m_req_id), .m_resp_val(m_resp_val), .m_resp_id(m_resp_id),
        .m_resp_rdata(m_resp_rdata), .err_unexp(err_unexp)
    );

    core_mem_arb #(.ARB_RR(0), .NC_ORDER(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr),
        .i_req_ack(fp_i_req_ack), .i_ack_rdata(fp_i_ack_rdata),
        .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
        .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
        .d_req_ack(fp_d_req_ack), .d_ack_rdata(fp_d_ack_rdata),
        .m_req_val(fp_m_req_val), .m_req_ready(m_req_ready), .m_req_addr(fp_m_req_addr),
        .m_req_cop(fp_m_req_cop), .m_req_wdata(fp_m_req_wdata), .m_req_size(fp_m_req_size),
        .m_req_id(fp_m_req_id), .m_resp_val(m_resp_val), .m_resp_id(m_resp_id),
        .m_resp_rdata(m_resp_rdata), .err_unexp(fp_err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_req_val    = 1'b0;
        i_req_addr   = '0;
        d_req_val    = 1'b0;
        d_req_addr   = '0;
        d_req_cop    = '0;
        d_req_wdata  = '0;
        d_req_size   = '0;
        m_req_ready  = 1'b0;
        m_resp_val   = 1'b0;
        m_resp_id    = 1'b0;
        m_resp_rdata = '0;
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        i_req_val  = 1'b1;
        d_req_val  = 1'b1;
        m_resp_val = 1'b1;
        m_resp_id  = 1'b1;
        m_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, m_req_id} !== 72'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got val=%b addr=%h cop=%b wdata=%h size=%b id=%b, want all zero",
                     m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, m_req_id);
        end
        n_cmp++;
        if ({i_req_ack, d_req_ack, err_unexp} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset_acks: got i_ack=%b d_ack=%b err=%b, want 000", i_req_ack, d_req_ack, err_unexp);
        end
        clear_inputs();
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, err_unexp} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got val=%b err=%b, want 00", m_req_val, err_unexp);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req_addr  = 32'h100;
        i_req_val   = 1'b1;
        m_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_req_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_latency: got val=%b, want 0", m_req_val);
        end
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_addr, m_req_id, m_req_cop, m_req_size, m_req_wdata} !==
            {1'b1, 32'h100, 1'b0, 3'b000, 3'b100, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL fetch_issue: got val=%b addr=%h id=%b cop=%b size=%b wdata=%h, want 1 100 0 000 100 0",
                     m_req_val, m_req_addr, m_req_id, m_req_cop, m_req_size, m_req_wdata);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_req_val !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL fetch_no_reissue: cycle %0d got val=%b, want 0", k, m_req_val);
            end
        end
        @(posedge clk);
        #1;
        m_resp_val   = 1'b1;
        m_resp_id    = 1'b0;
        m_resp_rdata = 32'h13;
        @(negedge clk);
        n_cmp++;
        if ({i_req_ack, d_req_ack, i_ack_rdata} !== {1'b1, 1'b0, 32'h13}) begin
            n_fail++;
            $display("[TB] FAIL fetch_ack: got i_ack=%b d_ack=%b rdata=%h, want 1 0 00000013",
                     i_req_ack, d_req_ack, i_ack_rdata);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b0;
        i_req_val  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i_req_ack, err_unexp} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL fetch_after_ack: got i_ack=%b err=%b, want 00", i_req_ack, err_unexp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_req_addr  = 32'h300;
        d_req_addr  = 32'h400;
        d_req_cop   = 3'b000;
        d_req_wdata = 32'h55;
        d_req_size  = 3'b010;
        i_req_val   = 1'b1;
        d_req_val   = 1'b1;
        m_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_id, m_req_addr} !== {1'b1, 1'b0, 32'h300}) begin
            n_fail++;
            $display("[TB] FAIL rr_first_i: got val=%b id=%b addr=%h, want 1 0 300", m_req_val, m_req_id, m_req_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_id, m_req_addr, m_req_cop, m_req_size, m_req_wdata} !==
            {1'b1, 1'b1, 32'h400, 3'b000, 3'b010, 32'h55}) begin
            n_fail++;
            $display("[TB] FAIL rr_second_d: got val=%b id=%b addr=%h cop=%b size=%b wdata=%h, want 1 1 400 000 010 55",
                     m_req_val, m_req_id, m_req_addr, m_req_cop, m_req_size, m_req_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (m_req_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rr_idle: got val=%b, want 0", m_req_val);
        end
        @(posedge clk);
        #1;
        m_resp_val   = 1'b1;
        m_resp_id    = 1'b1;
        m_resp_rdata = 32'hAAAA0001;
        @(negedge clk);
        n_cmp++;
        if ({d_req_ack, i_req_ack, d_ack_rdata} !== {1'b1, 1'b0, 32'hAAAA0001}) begin
            n_fail++;
            $display("[TB] FAIL rr_d_resp: got d_ack=%b i_ack=%b rdata=%h, want 1 0 aaaa0001",
                     d_req_ack, i_req_ack, d_ack_rdata);
        end
        @(posedge clk);
        #1;
        d_req_val    = 1'b0;
        m_resp_id    = 1'b0;
        m_resp_rdata = 32'hBBBB0002;
        @(negedge clk);
        n_cmp++;
        if ({i_req_ack, d_req_ack, i_ack_rdata} !== {1'b1, 1'b0, 32'hBBBB0002}) begin
            n_fail++;
            $display("[TB] FAIL rr_i_resp: got i_ack=%b d_ack=%b rdata=%h, want 1 0 bbbb0002",
                     i_req_ack, d_req_ack, i_ack_rdata);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b0;
        i_req_val  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, err_unexp} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL rr_done: got val=%b err=%b, want 00", m_req_val, err_unexp);
        end
    endtask

    task automatic test_write_stall();
        do_reset();
        m_req_ready = 1'b0;
        d_req_addr  = 32'h200;
        d_req_cop   = 3'b001;
        d_req_wdata = 32'hDEADBEEF;
        d_req_size  = 3'b010;
        d_req_val   = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, m_req_id} !==
                {1'b1, 32'h200, 3'b001, 32'hDEADBEEF, 3'b010, 1'b1}) begin
                n_fail++;
                $display("[TB] FAIL stall_hold: cycle %0d got val=%b addr=%h cop=%b wdata=%h size=%b id=%b",
                         k, m_req_val, m_req_addr, m_req_cop, m_req_wdata, m_req_size, m_req_id);
            end
        end
        @(posedge clk);
        #1 m_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_addr} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("[TB] FAIL stall_accept: got val=%b addr=%h, want 1 200", m_req_val, m_req_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (m_req_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_drain: got val=%b, want 0", m_req_val);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b1;
        m_resp_id  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({d_req_ack, i_req_ack} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL write_ack: got d_ack=%b i_ack=%b, want 10", d_req_ack, i_req_ack);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b0;
        d_req_val  = 1'b0;
    endtask

    task automatic test_nc_order();
        do_reset();
        m_req_ready = 1'b1;
        d_req_addr  = 32'h500;
        d_req_cop   = 3'b010;
        d_req_size  = 3'b010;
        d_req_val   = 1'b1;
        @(posedge clk);
        #1;
        i_req_addr = 32'h600;
        i_req_val  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_id, m_req_cop} !== {1'b1, 1'b1, 3'b010}) begin
            n_fail++;
            $display("[TB] FAIL nc_issue: got val=%b id=%b cop=%b, want 1 1 010", m_req_val, m_req_id, m_req_cop);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (m_req_val !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL nc_block: cycle %0d got val=%b, want 0", k, m_req_val);
            end
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b1;
        m_resp_id  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({d_req_ack, m_req_val} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL nc_ack: got d_ack=%b val=%b, want 10", d_req_ack, m_req_val);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b0;
        d_req_val  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (m_req_val !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nc_ack_plus1: got val=%b, want 0", m_req_val);
        end
        @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_id, m_req_addr} !== {1'b1, 1'b0, 32'h600}) begin
            n_fail++;
            $display("[TB] FAIL nc_i_release: got val=%b id=%b addr=%h, want 1 0 600", m_req_val, m_req_id, m_req_addr);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b1;
        m_resp_id  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_req_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nc_i_ack: got i_ack=%b, want 1", i_req_ack);
        end
        @(posedge clk);
        #1;
        m_resp_val = 1'b0;
        i_req_val  = 1'b0;
    endtask

    task automatic test_unexpected();
        do_reset();
        @(posedge clk);
        #1;
        m_resp_val   = 1'b1;
        m_resp_id    = 1'b1;
        m_resp_rdata = 32'h99;
        @(negedge clk);
        n_cmp++;
        if ({d_req_ack, i_req_ack, err_unexp} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL unexp_same_cycle: got d_ack=%b i_ack=%b err=%b, want 000", d_req_ack, i_req_ack, err_unexp);
        end
        @(posedge clk);
        #1 m_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL unexp_set: got err=%b, want 1", err_unexp);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL unexp_sticky: got err=%b, want 1", err_unexp);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_req_addr  = 32'h700;
        i_req_val   = 1'b1;
        m_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_req_val, m_req_addr} !== {1'b1, 32'h700}) begin
            n_fail++;
            $display("[TB] FAIL async_pre: got val=%b addr=%h, want 1 700", m_req_val, m_req_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_req_val, m_req_addr, err_unexp} !== {1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL async_clear: got val=%b addr=%h err=%b, want 0 0 0", m_req_val, m_req_addr, err_unexp);
        end
        i_req_val = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_resp_val = 1'b1;
        m_resp_id  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (i_req_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_stale_ack: got i_ack=%b, want 0", i_req_ack);
        end
        @(posedge clk);
        #1 m_resp_val = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_unexp !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL async_stale_err: got err=%b, want 1", err_unexp);
        end
    endtask

    // Responses are returned in the same cycle the fixed-priority instance issues.
    task automatic test_fixed_priority();
        logic exp_id;
        do_reset();
        m_req_ready = 1'b1;
        i_req_addr  = 32'h900;
        d_req_addr  = 32'h800;
        i_req_val   = 1'b1;
        d_req_val   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (fp_m_req_val) begin
                m_resp_val   = 1'b1;
                m_resp_id    = fp_m_req_id;
                m_resp_rdata = 32'(32'h1000 + k);
            end else begin
                m_resp_val = 1'b0;
            end
            @(negedge clk);
            exp_id = (k % 2 == 1) ? 1'b1 : 1'b0;
            n_cmp++;
            if ({fp_m_req_val, fp_m_req_id, fp_m_req_addr} !== {1'b1, exp_id, exp_id ? 32'h800 : 32'h900}) begin
                n_fail++;
                $display("[TB] FAIL fp_grant: cycle %0d got val=%b id=%b addr=%h, want 1 %b", k,
                         fp_m_req_val, fp_m_req_id, fp_m_req_addr, exp_id);
            end
            n_cmp++;
            if ({fp_i_req_ack, fp_d_req_ack} !== {~exp_id, exp_id}) begin
                n_fail++;
                $display("[TB] FAIL fp_ack: cycle %0d got i_ack=%b d_ack=%b, want %b %b", k,
                         fp_i_req_ack, fp_d_req_ack, ~exp_id, exp_id);
            end
            if (k == 1) begin
                n_cmp++;
                if ({m_req_val, m_req_id} !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL rr_vs_fp_first: got val=%b id=%b, want 1 0", m_req_val, m_req_id);
                end
            end
        end
        @(posedge clk);
        #1 clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_write_stall();
        test_nc_order();
        test_unexpected();
        test_async_reset();
        test_fixed_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_mem_arb.md
# core_mem_arb

- Sits directly downstream of `core_top`.
- Merges the core's instruction request port (`i_req_*`) and data request port (`d_req_*`) onto one memory request channel, tagging each request with a source id.
- Issues requests through a registered output stage.
- Tracks one outstanding request per source and routes id-tagged responses back as `i_req_ack`/`d_req_ack` pulses with read data.

## Interface
Parameters:
- `ARB_RR`, default 1: 1 = round-robin between I and D; 0 = fixed data priority.
- `NC_ORDER`, default 1: 1 = block instruction issue while a non-cacheable data request (`d_req_cop[1]`) is pending.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_req_val`  in  1  instruction request valid; held with stable addr until `i_req_ack`
- `i_req_addr`  in  32  instruction fetch address
- `i_req_ack`  out  1  instruction response pulse
- `i_ack_rdata`  out  32  instruction read data, valid with `i_req_ack`
- `d_req_val`  in  1  data request valid; held stable until `d_req_ack`
- `d_req_addr`  in  32  data address
- `d_req_cop`  in  3  data opcode: bit0 = write, bit1 = non-cacheable
- `d_req_wdata`  in  32  write data
- `d_req_size`  in  3  access size code
- `d_req_ack`  out  1  data response pulse
- `d_ack_rdata`  out  32  data read data
- `m_req_val`  out  1  memory request valid
- `m_req_ready`  in  1  memory accepts the request when `m_req_val & m_req_ready`
- `m_req_addr`  out  32  request address
- `m_req_cop`  out  3  opcode
- `m_req_wdata`  out  32  write data
- `m_req_size`  out  3  size code
- `m_req_id`  out  1  source id: 0 = I, 1 = D
- `m_resp_val`  in  1  response valid, one cycle, always accepted
- `m_resp_id`  in  1  response source id
- `m_resp_rdata`  in  32  response data; writes also return a response
- `err_unexp`  out  1  sticky: a response arrived for a source with no pending request

## Operation
Per-source state:
- `pend_i` and `pend_d` are set when that source's request is loaded into the output register.
- Each is cleared by its matching response.

Eligibility:
- I is eligible when `i_req_val & ~pend_i`, and additionally `~(NC_ORDER & pend_d & pend_nc)`.
- D is eligible when `d_req_val & ~pend_d`.
- `pend_nc` records `d_req_cop[1]` of the pending D request.

Output register:
- The register is free when `~m_req_val | m_req_ready`.
- When free and at least one source is eligible, load the granted source: addr, cop, wdata, size and id.
- I requests load `cop = 3'b000`, `size = 3'b100`, `wdata = 0`.
- When free and nothing is eligible, `m_req_val` drops to 0.
- While `m_req_val & ~m_req_ready`, all output fields hold.

Arbitration:
- `ARB_RR=1`: with both eligible, grant the source not granted last; `last_grant` updates on every load.
- `ARB_RR=0`: D always wins.

Response routing:
- `i_req_ack = m_resp_val & ~m_resp_id & pend_i`.
- `d_req_ack = m_resp_val & m_resp_id & pend_d`.
- `i_ack_rdata` and `d_ack_rdata` both equal `m_resp_rdata`. This path is combinational.
- Responses may return out of order relative to issue.

Unexpected response:
- If `m_resp_val` arrives for a source whose pend flag is clear, no ack is generated.
- `err_unexp` sets on the next edge and stays set until reset.

Capacity: at most 2 requests are outstanding, one per source.

## Timing
- Reset values: `m_req_val` = 0, all `m_req_*` fields = 0, `pend_i` = `pend_d` = `pend_nc` = 0, `last_grant` = D (so I wins the first tie), `err_unexp` = 0.
- Acks are combinational from `m_resp_*`, so they are 0 during reset.
- Issue latency: a request eligible in cycle N appears on `m_req_*` in cycle N+1.
- Response latency: zero, from `m_resp_val` to the ack.
- Ack cycle: the pend flag is still set in the ack cycle, so a held request is never re-issued.
- The flag clears at the edge, so the source's next request is eligible in cycle ack+1.
- Response and load in the same cycle for different sources: both take effect.
- Response and load in the same cycle for the same source cannot happen (the pend flag blocks the load).
- Back-to-back: with `m_req_ready` = 1 the register loads every cycle. Maximum throughput is one request per cycle, alternating sources when both are idle and requesting.
- Reset asserted mid-transaction: all state clears immediately and asynchronously. A response arriving after reset release sets `err_unexp`.

## Test plan
- Reset, then `i_req_val`=1, addr 0x100, `m_req_ready`=1 → cycle 1: `m_req_val`=1, addr 0x100, id 0, cop 0, size 4. No second issue until a response with `m_resp_id`=0, rdata 0x13 → `i_req_ack`=1, `i_ack_rdata`=0x13.
- I and D requesting together, `ARB_RR`=1 → I issued first, then D on the next cycle. Responses returned D first → `d_req_ack` precedes `i_req_ack`, with correct data.
- D write (cop 3'b001, addr 0x200, wdata 0xDEADBEEF) with `m_req_ready`=0 for 3 cycles → outputs held stable, accepted on cycle 4. The write response produces `d_req_ack`.
- NC read (cop 3'b010) pending with `NC_ORDER`=1 and `i_req_val`=1 → no I issue until `d_req_ack`; I issues the cycle after.
- `m_resp_val` with id 1 while `pend_d`=0 → `d_req_ack`=0, `err_unexp`=1 from the next cycle and sticky.
- `ARB_RR`=0, both requesting continuously with instant responses → D granted on every free cycle the D port is eligible.
